pcs_tx_gearbox: RTL
===================

// Module: pcs_tx_gearbox
// PURPOSE
//  64b/66b TX gearbox for the PCS transmit path. It sits after the scrambler and sync-header insertion, and before the PMA.
//  Input is a 2-bit sync header plus a scrambled 64-bit payload, delivered as CNT_N parts of DATA_W bits.
//  Output is a continuous DATA_W-bit stream on the same clock.
//  To absorb the 2 extra header bits per block, it drops ready_o for one cycle every DATA_W/2 blocks.
// PARAMETERS
//  DATA_W  32            data part / PMA word width; legal values 16, 32, 64
//  BLOCK_W 64            scrambled payload width per block
//  HEAD_W  2             sync header width
//  CNT_N   BLOCK_W/DATA_W  parts per block
//  CNT_W   $clog2(CNT_N) (min 1)  part counter width
//  SEQ_N   DATA_W/HEAD_W blocks between two stall cycles
// PORTS
//  clk          in   1       single clock
//  nreset       in   1       asynchronous active-low reset
//  valid_i      in   1       upstream presents a part this cycle
//  ready_o      out  1       gearbox accepts a part this cycle
//  head_i       in   HEAD_W  sync header; sampled only on part 0 of a block
//  data_i       in   DATA_W  scrambled payload part, LSB = first transmitted
//  data_o       out  DATA_W  PMA word, bit 0 transmitted first
//  part_o       out  CNT_W   index of the next part expected (0 = block start)
//  underflow_o  out  1       sticky: valid_i was low while ready_o was high
// BEHAVIOUR
//  Reset (async, nreset=0):
//   - fill_q=0, part_q=0, data_o=0, underflow_o=0.
//   - ready_o=1 and part_o=0 immediately.
//  Transfer rule:
//   - A part is accepted when ready_o is 1.
//   - valid_i is expected to be high on every such cycle; this is a continuous-flow stream with no backpressure on upstream timing.
//  Bit buffer:
//   - buf_q holds fill_q pending bits, LSB-aligned; fill_q ranges 0..DATA_W.
//   - Internal buffer width is 2*DATA_W+HEAD_W.
//  Per cycle, ready_o=1, part_q==0:
//   - Append {data_i, head_i} above the fill_q pending bits.
//   - Emit the low DATA_W bits to data_o (registered).
//   - fill_q += HEAD_W.
//  Per cycle, ready_o=1, part_q!=0:
//   - Append data_i, emit the low DATA_W bits.
//   - fill_q is unchanged.
//  part_q advances on every ready cycle and wraps CNT_N-1 -> 0. part_o = part_q.
//  ready_o = !(fill_q==DATA_W && part_q==0), decoded combinationally from registers:
//   - When ready_o=0, data_o takes the DATA_W buffered bits and fill_q -> 0.
//   - part_q holds, and input is ignored.
//  Stall cadence:
//   - Exactly one stall after every SEQ_N blocks.
//   - Period = SEQ_N*CNT_N+1 = 33 cycles for the defaults.
//   - Fixed by fill arithmetic alone; no separate sequence counter is required.
//  Latency: bit 0 of an accepted header appears in data_o bit fill_q on the next cycle.
//  Underflow (valid_i=0 while ready_o=1):
//   - The part is replaced by all zeros; on part 0 the header becomes 2'b00, which is intentionally invalid so the link partner flags it.
//   - Counters advance exactly as for a real part, so alignment and cadence are preserved.
//   - underflow_o is set and stays 1 until reset.
//  valid_i during a stall cycle is ignored and is not an underflow.
//  Reset mid-block or mid-stall: all state clears asynchronously; the first cycle after release is a block start with fill 0.
//  data_o is never X after reset; all registers are reset.
// TESTING (DATA_W=32 unless noted)
//  1. Reset, then block with head=01, parts 0x03020100 and 0x07060504:
//     -> data_o=0x0C080401, then 0x1C181410; part_o sequence 0,1,0.
//  2. 16 back-to-back blocks, valid_i=1:
//     -> ready_o=0 exactly in cycle 32 after reset release, then in cycles 65, 98, ...
//     -> the output bit stream equals the concatenation of all {data,head} blocks, LSB first.
//  3. Drop valid_i on part 0 of block 3:
//     -> that block's header is emitted as 00 with a zero payload part; underflow_o=1 from the next cycle onward.
//     -> the stall still occurs at cycle 32.
//  4. Assert nreset=0 while fill_q=20, mid-block:
//     -> ready_o=1, part_o=0, data_o=0 immediately.
//     -> the next block's first word is {part0[29:0], head}.
//  5. DATA_W=16 and DATA_W=64 builds with random blocks:
//     -> stall every 8 blocks / every 32 blocks respectively (period 33).
//     -> the bit stream matches the reference model.
//  6. Hold valid_i=1 across a stall with changing data:
//     -> the stall-cycle input is not consumed; the next accepted part is the one presented when ready_o returns to 1.

Source files
------------

// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox: 64b/66b TX gearbox, {head, 64b payload} parts in -> continuous DATA_W-bit PMA words out.
// Latency: one cycle; header bit 0 of an accepted block lands in data_o bit fill_q on the following cycle.
// Backpressure: ready_o drops for one cycle every SEQ_N blocks to drain the accumulated header bits.
//
// Ports:
//   clk          single clock
//   nreset       asynchronous active-low reset
//   valid_i      upstream presents a part (expected high whenever ready_o is high)
//   ready_o      part accepted this cycle (combinational decode of registers)
//   head_i       sync header, sampled only on part 0 of a block
//   data_i       scrambled payload part, LSB transmitted first
//   data_o       registered PMA word, bit 0 transmitted first
//   part_o       index of the next part expected (0 = block start)
//   underflow_o  sticky flag: valid_i was low on a cycle with ready_o high
module pcs_tx_gearbox #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 64,
  parameter int HEAD_W  = 2,
  parameter int CNT_N   = BLOCK_W / DATA_W,
  parameter int CNT_W   = (CNT_N > 1) ? $clog2(CNT_N) : 1,
  parameter int SEQ_N   = DATA_W / HEAD_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  part_o,
  output logic              underflow_o
);

  localparam int FILL_W = $clog2(DATA_W + 1);
  localparam int INS_W  = DATA_W + HEAD_W;
  localparam int WIDE_W = 2 * DATA_W + HEAD_W;

  // Pending bits, LSB-aligned; bits at and above fill_q are always zero,
  // which lets the merge below be a plain OR.
  logic [DATA_W-1:0] buf_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  part_q;
  logic [DATA_W-1:0] data_q;
  logic              underflow_q;

  logic              blk_start;
  logic [DATA_W-1:0] in_dat;
  logic [HEAD_W-1:0] in_hd;
  logic [INS_W-1:0]  ins;
  logic [WIDE_W-1:0] merged;
  logic [CNT_W-1:0]  part_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              unused_hi;

  always_comb begin
    blk_start = (part_q == '0);
    // The buffer is full exactly when SEQ_N headers have accumulated; at a
    // block boundary that is the one cycle the gearbox can drain without input.
    ready_o = !((fill_q == FILL_W'(SEQ_N * HEAD_W)) && blk_start);

    // A missing part is replaced with zeros (header 00 on part 0) so the
    // stream keeps its alignment and the link partner sees an invalid header.
    in_dat = valid_i ? data_i : '0;
    in_hd  = valid_i ? head_i : '0;
    ins    = blk_start ? {in_dat, in_hd} : {{HEAD_W{1'b0}}, in_dat};

    merged = {{INS_W{1'b0}}, buf_q} | ({{DATA_W{1'b0}}, ins} << fill_q);

    part_nxt = (part_q == CNT_W'(CNT_N - 1)) ? '0 : part_q + CNT_W'(1);
    fill_nxt = blk_start ? fill_q + FILL_W'(HEAD_W) : fill_q;
  end

  // fill_q never exceeds DATA_W, so the merged value never reaches these bits.
  assign unused_hi = ^merged[WIDE_W-1:2*DATA_W];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q       <= '0;
      fill_q      <= '0;
      part_q      <= '0;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else if (!ready_o) begin
      // Stall: the buffer holds exactly one word; flush it, input is ignored.
      data_q <= buf_q;
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      data_q <= merged[DATA_W-1:0];
      buf_q  <= merged[2*DATA_W-1:DATA_W];
      fill_q <= fill_nxt;
      part_q <= part_nxt;
      if (!valid_i) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign part_o      = part_q;
  assign underflow_o = underflow_q;

endmodule
